wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_write_arbiter.sv | 51 +++++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared datapath constants, types and helpers for the write-back register file.
package wb_regfile_pkg;

    localparam int REG_COUNT   = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 8;
    localparam int RET_ADDR_W  = 14;
    localparam int LINK_HI_REG = 30;
    localparam int LINK_LO_REG = 31;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] addr_t;
    typedef logic [RET_ADDR_W-1:0] ret_addr_t;

    // Upper part of a return address, zero-extended to a register (goes to R30).
    function automatic data_t link_hi_data(input ret_addr_t ret);
        return data_t'(ret[RET_ADDR_W-1:DATA_W]);
    endfunction

    // Lower byte of a return address (goes to R31).
    function automatic data_t link_lo_data(input ret_addr_t ret);
        return ret[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / read bus of the register file.
// Handshake: there is none; every write enable and read index is sampled on
// each rising clock edge, and read data / conflict flag are valid one cycle later.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    data_t     wr_data_top;
    data_t     wr_data_bot;
    addr_t     wr_addr_top;
    addr_t     wr_addr_bot;
    logic [1:0] wen;
    logic      link_wen;
    ret_addr_t ret_addr;
    addr_t     rd_addr_a;
    addr_t     rd_addr_b;
    data_t     rd_data_a;
    data_t     rd_data_b;
    logic      wr_conflict;

    modport master (
        output wr_data_top, wr_data_bot, wr_addr_top, wr_addr_bot,
        output wen, link_wen, ret_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_conflict
    );

    modport slave (
        input  wr_data_top, wr_data_bot, wr_addr_top, wr_addr_bot,
        input  wen, link_wen, ret_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_conflict
    );

endinterface

// File: rtl/wb_write_arbiter.sv
// Resolves the three write sources (link, top, bottom) into one enable and one
// data word per register, and flags when two sources hit the same nonzero register.
module wb_write_arbiter
    import wb_regfile_pkg::*;
(
    input  logic                  link_wen_i,
    input  ret_addr_t             ret_addr_i,
    input  logic [1:0]            wen_i,
    input  addr_t                 wr_addr_top_i,
    input  data_t                 wr_data_top_i,
    input  addr_t                 wr_addr_bot_i,
    input  data_t                 wr_data_bot_i,
    output logic [REG_COUNT-1:0]  we_o,
    output data_t [REG_COUNT-1:0] wdata_o,
    output logic                  conflict_o
);

    logic hit_bot;
    logic hit_top;
    logic hit_link;

    // Per-register priority: link over top over bottom; R0 is never enabled.
    always_comb begin
        we_o       = '0;
        wdata_o    = '0;
        conflict_o = 1'b0;
        hit_bot    = 1'b0;
        hit_top    = 1'b0;
        hit_link   = 1'b0;
        for (int i = 1; i < REG_COUNT; i++) begin
            hit_bot  = wen_i[0] && (wr_addr_bot_i == addr_t'(i));
            hit_top  = wen_i[1] && (wr_addr_top_i == addr_t'(i));
            hit_link = link_wen_i && ((i == LINK_HI_REG) || (i == LINK_LO_REG));

            we_o[i] = hit_bot || hit_top || hit_link;
            if (hit_link) begin
                wdata_o[i] = (i == LINK_HI_REG) ? link_hi_data(ret_addr_i)
                                                : link_lo_data(ret_addr_i);
            end else if (hit_top) begin
                wdata_o[i] = wr_data_top_i;
            end else if (hit_bot) begin
                wdata_o[i] = wr_data_bot_i;
            end

            if ((hit_bot && hit_top) || (hit_bot && hit_link) || (hit_top && hit_link)) begin
                conflict_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32 x 8-bit write-back register file with two write ports, a link write
// (return address into R30/R31) and two registered read ports.
// Optional macro WB_REGFILE_BYPASS_EN: reads see same-cycle writes. When it is
// undefined, reads return pre-write contents and forwarding of the in-flight
// write-back value is left to the hazard unit.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clock,
    input  logic         nreset,
    wb_regfile_if.slave  rf_bus
);

    logic [REG_COUNT-1:0]  we;
    data_t [REG_COUNT-1:0] wdata;
    logic                  conflict_d;
    logic                  conflict_q;
    data_t                 regs_q [REG_COUNT];
    data_t                 rd_a_d;
    data_t                 rd_a_q;
    data_t                 rd_b_d;
    data_t                 rd_b_q;

    wb_write_arbiter u_arbiter (
        .link_wen_i    (rf_bus.link_wen),
        .ret_addr_i    (rf_bus.ret_addr),
        .wen_i         (rf_bus.wen),
        .wr_addr_top_i (rf_bus.wr_addr_top),
        .wr_data_top_i (rf_bus.wr_data_top),
        .wr_addr_bot_i (rf_bus.wr_addr_bot),
        .wr_data_bot_i (rf_bus.wr_data_bot),
        .we_o          (we),
        .wdata_o       (wdata),
        .conflict_o    (conflict_d)
    );

    // Read-port next values; R0 is held at zero so it reads 0 naturally.
    always_comb begin
        rd_a_d = regs_q[rf_bus.rd_addr_a];
        rd_b_d = regs_q[rf_bus.rd_addr_b];
`ifdef WB_REGFILE_BYPASS_EN
        if (we[rf_bus.rd_addr_a]) begin
            rd_a_d = wdata[rf_bus.rd_addr_a];
        end
        if (we[rf_bus.rd_addr_b]) begin
            rd_b_d = wdata[rf_bus.rd_addr_b];
        end
`endif
    end

    // Register array and read/conflict registers; reset wins over any write.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (we[i]) begin
                    regs_q[i] <= wdata[i];
                end
            end
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            conflict_q <= conflict_d;
        end
    end

    assign rf_bus.rd_data_a   = rd_a_q;
    assign rf_bus.rd_data_b   = rd_b_q;
    assign rf_bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a random run,
// with a reference model feeding expected-value queues.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    typedef struct packed {
        logic       rst_n;
        logic [1:0] w;
        logic [4:0] at;
        logic [7:0] dt;
        logic [4:0] ab;
        logic [7:0] db;
        logic       lw;
        logic [13:0] ret;
        logic [4:0] ra;
        logic [4:0] rb;
    } stim_t;

    logic clock;
    logic nreset;
    wb_regfile_if dut_if ();

    wb_regfile dut (
        .clock  (clock),
        .nreset (nreset),
        .rf_bus (dut_if.slave)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // scoreboard state
    logic [7:0] mdl [32];
    logic [7:0] exp_q [$];
    logic [7:0] exp_b_q [$];
    logic [0:0] exp_c_q [$];
    int n_cmp;
    int n_fail;

    function automatic stim_t mk(input logic rst_n, input logic [1:0] w,
                                 input logic [4:0] at, input logic [7:0] dt,
                                 input logic [4:0] ab, input logic [7:0] db,
                                 input logic lw, input logic [13:0] ret,
                                 input logic [4:0] ra, input logic [4:0] rb);
        stim_t s;
        s.rst_n = rst_n; s.w = w; s.at = at; s.dt = dt; s.ab = ab; s.db = db;
        s.lw = lw; s.ret = ret; s.ra = ra; s.rb = rb;
        return s;
    endfunction

    // driver: applies one cycle of stimulus, predicts outputs, advances one edge
    task automatic drive(input stim_t s);
        logic [7:0] nxt [32];
        int hits [32];
        logic conf;
        nreset             = s.rst_n;
        dut_if.wen         = s.w;
        dut_if.wr_addr_top = s.at;
        dut_if.wr_data_top = s.dt;
        dut_if.wr_addr_bot = s.ab;
        dut_if.wr_data_bot = s.db;
        dut_if.link_wen    = s.lw;
        dut_if.ret_addr    = s.ret;
        dut_if.rd_addr_a   = s.ra;
        dut_if.rd_addr_b   = s.rb;
        nxt = mdl;
        for (int i = 0; i < 32; i++) hits[i] = 0;
        // apply lowest priority first so higher-priority sources overwrite
        if (s.w[0] && s.ab != 0) begin nxt[s.ab] = s.db; hits[s.ab]++; end
        if (s.w[1] && s.at != 0) begin nxt[s.at] = s.dt; hits[s.at]++; end
        if (s.lw) begin
            nxt[30] = {2'b00, s.ret[13:8]};
            nxt[31] = s.ret[7:0];
            hits[30]++;
            hits[31]++;
        end
        conf = 1'b0;
        for (int i = 1; i < 32; i++) if (hits[i] > 1) conf = 1'b1;
        if (!s.rst_n) begin
            exp_q.push_back(8'h00);
            exp_b_q.push_back(8'h00);
            exp_c_q.push_back(1'b0);
            for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        end else begin
`ifdef WB_REGFILE_BYPASS_EN
            exp_q.push_back(nxt[s.ra]);
            exp_b_q.push_back(nxt[s.rb]);
`else
            exp_q.push_back(mdl[s.ra]);
            exp_b_q.push_back(mdl[s.rb]);
`endif
            exp_c_q.push_back(conf);
            mdl = nxt;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t s [2];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b0, 2'b11, 5'd1, 8'h12, 5'd2, 8'h34, 1'b1, 14'h1FFF, 5'd0, 5'd0);
        s[1] = mk(1'b0, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd1, 5'd31);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL reset_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
        end
        n_cmp++;
        if (dut_if.wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_conflict: got %b expected 0", dut_if.wr_conflict);
        end
    endtask

    task automatic test_basic_write();
        stim_t s [2];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b1, 2'b10, 5'd5, 8'hA5, 5'd0, 8'h00, 1'b0, 14'h0, 5'd0, 5'd0);
        s[1] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd5, 5'd6);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL basic_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
        end
        n_cmp++;
        if (dut_if.rd_data_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_r5: got %h expected a5", dut_if.rd_data_a);
        end
    endtask

    task automatic test_r0();
        stim_t s [2];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b1, 2'b11, 5'd0, 8'hFF, 5'd0, 8'hFF, 1'b0, 14'h0, 5'd0, 5'd0);
        s[1] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL r0_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
            n_cmp++;
            if (dut_if.wr_conflict !== 1'b0) begin
                n_fail++;
                $display("FAIL r0_conflict_c%0d: got %b expected 0", k, dut_if.wr_conflict);
            end
        end
        n_cmp++;
        if (dut_if.rd_data_a !== 8'h00) begin
            n_fail++;
            $display("FAIL r0_read: got %h expected 00", dut_if.rd_data_a);
        end
    endtask

    task automatic test_collision();
        stim_t s [2];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b1, 2'b11, 5'd7, 8'h11, 5'd7, 8'h22, 1'b0, 14'h0, 5'd0, 5'd0);
        s[1] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd7, 5'd7);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL coll_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
            n_cmp++;
            if (dut_if.wr_conflict !== (k == 0 ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL coll_flag_c%0d: got %b expected %b", k, dut_if.wr_conflict, (k == 0));
            end
        end
        n_cmp++;
        if (dut_if.rd_data_a !== 8'h11) begin
            n_fail++;
            $display("FAIL coll_r7: got %h expected 11", dut_if.rd_data_a);
        end
    endtask

    task automatic test_link();
        stim_t s [2];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b1, 2'b10, 5'd31, 8'h55, 5'd0, 8'h00, 1'b1, 14'h2ABC, 5'd0, 5'd0);
        s[1] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd30, 5'd31);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL link_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
            if (k == 0) begin
                n_cmp++;
                if (dut_if.wr_conflict !== 1'b1) begin
                    n_fail++;
                    $display("FAIL link_conflict: got %b expected 1", dut_if.wr_conflict);
                end
            end
        end
        n_cmp++;
        if ({dut_if.rd_data_a, dut_if.rd_data_b} !== 16'h2ABC) begin
            n_fail++;
            $display("FAIL link_r30_r31: got %h %h expected 2a bc", dut_if.rd_data_a, dut_if.rd_data_b);
        end
    endtask

    task automatic test_bypass();
        stim_t s [2];
        logic [7:0] ea, eb, want;
        logic [0:0] ec;
`ifdef WB_REGFILE_BYPASS_EN
        want = 8'h3C;
`else
        want = 8'h00;
`endif
        s[0] = mk(1'b1, 2'b10, 5'd9, 8'h3C, 5'd0, 8'h00, 1'b0, 14'h0, 5'd9, 5'd9);
        s[1] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd9, 5'd0);
        for (int k = 0; k < 2; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL bypass_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
            if (k == 0) begin
                n_cmp++;
                if (dut_if.rd_data_a !== want) begin
                    n_fail++;
                    $display("FAIL bypass_same_cycle: got %h expected %h", dut_if.rd_data_a, want);
                end
            end
        end
        n_cmp++;
        if (dut_if.rd_data_a !== 8'h3C) begin
            n_fail++;
            $display("FAIL bypass_after: got %h expected 3c", dut_if.rd_data_a);
        end
    endtask

    task automatic test_mid_write_reset();
        stim_t s [3];
        logic [7:0] ea, eb;
        logic [0:0] ec;
        s[0] = mk(1'b1, 2'b11, 5'd3, 8'h33, 5'd4, 8'h44, 1'b0, 14'h0, 5'd0, 5'd0);
        s[1] = mk(1'b0, 2'b11, 5'd3, 8'h77, 5'd4, 8'h88, 1'b0, 14'h0, 5'd3, 5'd4);
        s[2] = mk(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 14'h0, 5'd3, 5'd4);
        for (int k = 0; k < 3; k++) begin
            drive(s[k]);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL midrst_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
        end
        n_cmp++;
        if ({dut_if.rd_data_a, dut_if.rd_data_b} !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_r3_r4: got %h %h expected 00 00", dut_if.rd_data_a, dut_if.rd_data_b);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [7:0] ea, eb;
        logic [0:0] ec;
        for (int k = 0; k < 400; k++) begin
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.w     = 2'($urandom_range(0, 3));
            s.at    = 5'($urandom_range(0, 31));
            s.dt    = 8'($urandom_range(0, 255));
            s.ab    = ($urandom_range(0, 3) == 0) ? s.at : 5'($urandom_range(0, 31));
            s.db    = 8'($urandom_range(0, 255));
            s.lw    = ($urandom_range(0, 7) == 0);
            s.ret   = 14'($urandom_range(0, 16383));
            s.ra    = ($urandom_range(0, 2) == 0) ? s.at : 5'($urandom_range(0, 31));
            s.rb    = ($urandom_range(0, 2) == 0) ? s.ab : 5'($urandom_range(28, 31));
            drive(s);
            ea = exp_q.pop_front(); eb = exp_b_q.pop_front(); ec = exp_c_q.pop_front();
            n_cmp++;
            if ({dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict} !== {ea, eb, ec}) begin
                n_fail++;
                $display("FAIL rand_c%0d: got a=%h b=%h c=%b expected a=%h b=%h c=%b",
                         k, dut_if.rd_data_a, dut_if.rd_data_b, dut_if.wr_conflict, ea, eb, ec);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        nreset             = 1'b0;
        dut_if.wen         = 2'b00;
        dut_if.wr_addr_top = '0;
        dut_if.wr_data_top = '0;
        dut_if.wr_addr_bot = '0;
        dut_if.wr_data_bot = '0;
        dut_if.link_wen    = 1'b0;
        dut_if.ret_addr    = '0;
        dut_if.rd_addr_a   = '0;
        dut_if.rd_addr_b   = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_basic_write();
        test_r0();
        test_collision();
        test_link();
        test_bypass();
        test_mid_write_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
